cc_ctrl: RTL and testbench

Condition-code sequencer for the LC-3b datapath. It sits between decode/execute and the `cc` unit and owns the CC register's `ld_cc` strobe. It counts in-flight CC-writing operations, holds a BR instruction until every older CC write has landed, and then resolves the branch against the registered n/z/p flags.

---
 rtl/cc_ctrl.sv | 72 +++++++
 tb/tb_cc_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/cc_ctrl.sv
// cc_ctrl: counts in-flight CC writers, holds BR until they land, resolves it; `define CC_CTRL_BYPASS_EN resolves straight from data.
module cc_ctrl #(
   parameter int MAX_PEND = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic        op_sets_cc,
   output logic        op_ready,
   input  logic        result_valid,
   input  logic [15:0] data,
   output logic        ld_cc,
   input  logic        cc_n,
   input  logic        cc_z,
   input  logic        cc_p,
   input  logic        br_valid,
   input  logic [2:0]  br_nzp,
   output logic        br_ready,
   output logic        br_done,
   output logic        br_taken,
   output logic        err
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESOLVE = 2'd2;
   logic [1:0] state;
   logic [2:0] pend, nzp_q;
   logic       inc, byp_hit;
   assign ld_cc    = result_valid & (pend != 3'd0);
   assign op_ready = (state == IDLE) & (pend < 3'(MAX_PEND));
   assign br_ready = state == IDLE;
   assign br_done  = state == RESOLVE;
   assign inc      = op_valid & op_ready & op_sets_cc & ~br_valid;
`ifdef CC_CTRL_BYPASS_EN
   logic       byp_q, taken_q;
   logic [2:0] dflags;
   assign dflags   = {data[15], data == 16'd0, ~data[15] & (data != 16'd0)};
   assign byp_hit  = (state == WAIT) & (pend == 3'd1) & result_valid;
   assign br_taken = br_done & (byp_q ? taken_q : |(nzp_q & {cc_n, cc_z, cc_p}));
   always_ff @(posedge clk)
      if (rst) begin
         byp_q   <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         byp_q   <= byp_hit;
         taken_q <= |(nzp_q & dflags);
      end
`else
   logic unused;
   assign unused   = ^data;
   assign byp_hit  = 1'b0;
   assign br_taken = br_done & |(nzp_q & {cc_n, cc_z, cc_p});
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         pend  <= 3'd0;
         nzp_q <= 3'd0;
         err   <= 1'b0;
      end else begin
         pend <= pend + {2'b0, inc} - {2'b0, ld_cc};
         err  <= err | (result_valid & (pend == 3'd0));
         case (state)
            IDLE:
               if (br_valid) begin
                  nzp_q <= br_nzp;
                  state <= (pend == 3'd0) ? RESOLVE : WAIT;
               end
            WAIT:
               if ((pend == 3'd0) | byp_hit) state <= RESOLVE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_cc_ctrl.sv
// tb_cc_ctrl: directed plan plus random traffic against a cycle-numbered branch scoreboard.
module tb_cc_ctrl;
   localparam int MAXP = 3;
   logic        clk = 1'b0, rst = 1'b1;
   logic        op_valid = 1'b0, op_sets_cc = 1'b0, result_valid = 1'b0, br_valid = 1'b0;
   logic [15:0] data = 16'd0;
   logic [2:0]  br_nzp = 3'd0;
   logic        op_ready, ld_cc, br_ready, br_done, br_taken, err;
   logic [2:0]  cc = 3'd0;
   int          errors = 0, checks = 0, cyc = 0;
   int          m_pend = 0, m_done_at = -1, m_acc = 0;
   bit          m_busy = 0, m_err = 0;
   logic [2:0]  m_nzp = 3'd0;
   always #5 clk = ~clk;
   cc_ctrl #(.MAX_PEND(MAXP)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_sets_cc(op_sets_cc), .op_ready(op_ready),
      .result_valid(result_valid), .data(data), .ld_cc(ld_cc),
      .cc_n(cc[2]), .cc_z(cc[1]), .cc_p(cc[0]),
      .br_valid(br_valid), .br_nzp(br_nzp), .br_ready(br_ready),
      .br_done(br_done), .br_taken(br_taken), .err(err)
   );
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask
   function automatic logic [2:0] flags(input logic [15:0] d);
      return {d[15], d == 16'd0, !d[15] && d != 16'd0};
   endfunction
   // one cycle: drive, check outputs against the scoreboard, then advance the scoreboard
   task automatic step(input logic r, input logic ov, input logic os, input logic rv,
                       input logic [15:0] d, input logic bv, input logic [2:0] bn);
      bit ld, done, oacc;
      @(negedge clk);
      rst = r; op_valid = ov; op_sets_cc = os; result_valid = rv; data = d; br_valid = bv; br_nzp = bn;
      #1;
      ld   = rv && m_pend != 0;
      done = m_busy && cyc == m_done_at;
      check("op_ready", op_ready, !m_busy && m_pend < MAXP);
      check("br_ready", br_ready, !m_busy);
      check("ld_cc", ld_cc, ld);
      check("br_done", br_done, done);
      check("br_taken", br_taken, done && |(m_nzp & cc));
      check("err", err, m_err);
      @(posedge clk);
      if (r) begin
         m_pend = 0; m_busy = 0; m_err = 0; m_nzp = 0; cc = 0; m_done_at = -1;
      end else begin
         oacc = !m_busy && !bv && ov && m_pend < MAXP;
         if (rv && m_pend == 0) m_err = 1;
         if (done) m_busy = 0;
         else if (!m_busy && bv) begin
            m_busy = 1; m_nzp = bn; m_acc = cyc;
            m_done_at = m_pend == 0 ? cyc + 1 : -1;
         end
         if (m_busy && m_done_at < 0 && ld && m_pend == 1)
`ifdef CC_CTRL_BYPASS_EN
            m_done_at = cyc > m_acc ? cyc + 1 : cyc + 2;
`else
            m_done_at = cyc + 2;
`endif
         m_pend = m_pend + int'(oacc && os) - int'(ld);
         if (ld) cc = flags(d);
      end
      cyc++;
   endtask
   task automatic idle();
      step(0, 0, 0, 0, 16'd0, 0, 3'd0);
   endtask
   task automatic op();
      step(0, 1, 1, 0, 16'd0, 0, 3'd0);
   endtask
   task automatic res(input logic [15:0] d);
      step(0, 0, 0, 1, d, 0, 3'd0);
   endtask
   task automatic br(input logic [2:0] m);
      step(0, 0, 0, 0, 16'd0, 1, m);
   endtask
   initial begin
      logic r, bv, ov, os, rv;
      logic [15:0] d;
      step(1, 0, 0, 0, 16'd0, 0, 3'd0);
      step(1, 0, 0, 0, 16'd0, 0, 3'd0);
      idle();
      op(); res(16'd0);
      br(3'b010); idle(); br(3'b101); idle(); idle();
      op(); op(); br(3'b100); idle(); idle();
      res(16'hFFFB); res(16'd7); idle(); idle(); idle();
      op(); op(); op(); op();
      step(0, 1, 1, 1, 16'd3, 0, 3'd0);
      op(); res(16'd1); res(16'd2); res(16'd3); idle();
      br(3'b111); idle(); br(3'b000); idle(); idle();
      res(16'd9); idle(); idle();
      check("err_sticky", err, 1'b1);
      step(1, 0, 0, 0, 16'd0, 0, 3'd0);
      step(1, 0, 0, 0, 16'd0, 0, 3'd0);
      op(); op(); br(3'b001); idle();
      step(1, 0, 0, 0, 16'd0, 0, 3'd0);
      idle(); idle();
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(99) == 0;
         bv = $urandom_range(9) == 0;
         ov = !bv && $urandom_range(9) < 4;
         os = $urandom_range(9) < 7;
         rv = m_pend != 0 ? $urandom_range(9) < 4 : $urandom_range(99) < 3;
         d  = $urandom_range(4) == 0 ? 16'd0 : 16'($urandom);
         step(r, ov, os, rv, d, bv, 3'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
